keypad_matrix_scanner: RTL and testbench
========================================

// Module: keypad_matrix_scanner
// PURPOSE
//  Parametrised row/column key-matrix scanner for the elevator panel. Drives one-hot rows,
//  samples columns, debounces whole scan frames, encodes one key, and delivers one event per
//  press on a valid/ready handshake to the call queue. Replaces the fixed 4x4 free-running scanner.
// PARAMETERS
//  ROWS            4     matrix rows driven (>=2)
//  COLS            4     matrix columns sensed (>=1)
//  SCAN_DIV        1000  clk cycles each row is driven (dwell, >=2)
//  DEBOUNCE_FRAMES 3     consecutive identical frames before press/release is accepted (>=1)
//  REPEAT_DELAY    50    frames held before first auto-repeat (used only with KEYPAD_REPEAT_EN)
//  REPEAT_RATE     10    frames between later auto-repeats (used only with KEYPAD_REPEAT_EN)
//  CODE_W          $clog2(ROWS*COLS) key code width (derived, not overridden)
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rst         in   1       asynchronous, active-high reset
//  col         in   COLS    column sense, 1 = key closed on the driven row
//  row         out  ROWS    one-hot row drive, active high
//  key_valid   out  1       press event available
//  key_ready   in   1       consumer accepts event when key_valid & key_ready
//  key_code    out  CODE_W  row_idx*COLS + col_idx; stable while key_valid
//  key_held    out  1       debounced key currently down
//  key_multi   out  1       >1 key closed in the last evaluated frame
//  key_overrun out  1       one-cycle pulse: event dropped because key_valid was still pending
// BEHAVIOUR
//  Reset: row=1 (row 0), dwell/row counters 0, FSM IDLE, key_valid/key_held/key_multi/key_overrun=0,
//   key_code=0. Reset mid-frame discards the partial frame and any pending event.
//  Row drive: row index advances every SCAN_DIV cycles, ROWS-1 wraps to 0; row stays one-hot.
//  Sampling: col captured on the last dwell cycle of each row into the frame snapshot (settled).
//  Frame end = sample of row ROWS-1. Candidate = lowest-index closed key (row-major); none if empty.
//   key_multi updated at every frame end.
//  FSM, evaluated once per frame end; stable count resets on any candidate change:
//   IDLE:     candidate present -> PRESS, cnt=1.
//   PRESS:    same candidate -> cnt++; cnt==DEBOUNCE_FRAMES -> HELD, emit event; else mismatch -> IDLE.
//   HELD:     candidate != held code -> RELEASE, cnt=1.
//   RELEASE:  candidate != held code for DEBOUNCE_FRAMES frames -> IDLE; held code reappears -> HELD.
//  key_held=1 in HELD and RELEASE. A different key pressed while held only registers after release
//   completes and its own debounce.
//  Emit: if !key_valid: key_valid<=1, key_code<=code, one cycle after frame end. If key_valid
//   still pending: event dropped, key_code unchanged, key_overrun pulses one cycle.
//  Handshake: key_valid falls the cycle after valid&ready. key_ready ignored while !key_valid.
//   Accept and new emit on same cycle: new event wins (key_valid stays 1, new key_code).
//  Latency: press stable from frame start -> key_valid within DEBOUNCE_FRAMES*ROWS*SCAN_DIV+1 cycles.
// CONFIGURATION
//  KEYPAD_REPEAT_EN defined: in HELD, frame counter emits the held code again after REPEAT_DELAY
//   frames, then every REPEAT_RATE frames; counter clears on leaving HELD; overrun rules apply.
//  Undefined: exactly one event per debounced press; repeat counter and parameters unused.
// STRUCTURE
//  keypad_pkg: FSM state enum (IDLE, PRESS, HELD, RELEASE), code-width function, default params.
//  Sub-module keypad_row_driver: dwell divider + one-hot row ring; outputs row and sample/frame_end strobes.
//  Top: snapshot register, priority encoder, debounce FSM, output/handshake register.
// TESTING  (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_FRAMES=3; bench models col from row & key matrix)
//  Reset then idle 100 cycles -> row cycles 1,2,4,8 every 4 clks; key_valid=0, key_held=0.
//  Press r2c1 held, key_ready=1 -> single key_valid pulse, key_code=9, key_held=1; release ->
//   key_held=0 after 3 clear frames, no further event.
//  Press r1c3 bouncing every frame for 5 frames then stable -> exactly one event code=7.
//  Press r0c0 and r3c3 together -> key_code=0, key_multi=1.
//  key_ready=0, press code 5, release, press code 6 -> key_valid holds code 5, key_overrun pulses once.
//  Assert rst mid-dwell with key_valid=1 -> row=1, key_valid=0 immediately (async); KEYPAD_REPEAT_EN
//   build: hold code 2 for 70 frames -> events at frames 3, 53, 63.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and defaults for the keypad matrix scanner.
// Holds the debounce state encoding and the key-code width helper.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_HELD,
        ST_RELEASE
    } key_state_t;

    localparam int DEF_ROWS            = 4;
    localparam int DEF_COLS            = 4;
    localparam int DEF_SCAN_DIV        = 1000;
    localparam int DEF_DEBOUNCE_FRAMES = 3;
    localparam int DEF_REPEAT_DELAY    = 50;
    localparam int DEF_REPEAT_RATE     = 10;

    // Never returns 0 so a 1-key matrix still gets a legal bus width.
    function automatic int code_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/keypad_row_driver.sv
// Dwell divider plus one-hot row ring; strobes the settled sample point of each row.
// Latency: sample/frame_end are combinational on the last dwell cycle of a row.
// Backpressure: none, free-running from reset.
module keypad_row_driver #(
    parameter  int ROWS     = 4,
    parameter  int SCAN_DIV = 1000,
    localparam int IDX_W    = $clog2(ROWS),
    localparam int DIV_W    = $clog2(SCAN_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [ROWS-1:0]  row,
    output logic [IDX_W-1:0] row_idx,
    output logic             sample,
    output logic             frame_end
);

    logic [DIV_W-1:0] dwell;

    assign sample    = (dwell == DIV_W'(SCAN_DIV - 1));
    assign frame_end = sample && (row_idx == IDX_W'(ROWS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell   <= '0;
            row_idx <= '0;
        end else if (sample) begin
            dwell   <= '0;
            row_idx <= frame_end ? '0 : row_idx + 1'b1;
        end else begin
            dwell   <= dwell + 1'b1;
        end
    end

    always_comb begin
        row          = '0;
        row[row_idx] = 1'b1;
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Key-matrix scanner: whole-frame debounce, lowest-index key encode, one event per press (KEYPAD_REPEAT_EN adds auto-repeat).
// Latency: stable press reaches key_valid within DEBOUNCE_FRAMES*ROWS*SCAN_DIV+1 cycles.
// Backpressure: valid/ready; an event arriving while one is still pending is dropped and flagged on key_overrun.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter  int ROWS            = DEF_ROWS,
    parameter  int COLS            = DEF_COLS,
    parameter  int SCAN_DIV        = DEF_SCAN_DIV,
    parameter  int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
    parameter  int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter  int REPEAT_RATE     = DEF_REPEAT_RATE,
    localparam int CODE_W          = code_width(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COLS-1:0]   col,
    output logic [ROWS-1:0]   row,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [CODE_W-1:0] key_code,
    output logic              key_held,
    output logic              key_multi,
    output logic              key_overrun
);

    localparam int KEYS  = ROWS * COLS;
    localparam int IDX_W = $clog2(ROWS);
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

    if (ROWS < 2 || COLS < 1 || SCAN_DIV < 2 || DEBOUNCE_FRAMES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    end

    logic [IDX_W-1:0] row_idx;
    logic             sample;
    logic             frame_end;

    keypad_row_driver #(
        .ROWS     (ROWS),
        .SCAN_DIV (SCAN_DIV)
    ) u_row_driver (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .row_idx   (row_idx),
        .sample    (sample),
        .frame_end (frame_end)
    );

    logic [KEYS-1:0] snap;
    logic [KEYS-1:0] frame_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap <= '0;
        end else if (sample) begin
            snap[int'(row_idx)*COLS +: COLS] <= col;
        end
    end

    // The last row is sampled on the frame_end cycle itself, so take it live.
    always_comb begin
        frame_dat                         = snap;
        frame_dat[(ROWS-1)*COLS +: COLS]  = col;
    end

    logic              cand_vld;
    logic [CODE_W-1:0] cand_code;
    logic              cand_multi;
    int unsigned       n_closed;

    always_comb begin
        cand_vld  = 1'b0;
        cand_code = '0;
        n_closed  = 0;
        for (int i = KEYS - 1; i >= 0; i--) begin
            if (frame_dat[i]) begin
                cand_vld  = 1'b1;
                cand_code = CODE_W'(i);
                n_closed  = n_closed + 1;
            end
        end
        cand_multi = (n_closed > 1);
    end

    key_state_t        state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx, cnt_inc;
    logic [CODE_W-1:0] track, track_nx;
    logic              same;
    logic              emit;

    assign cnt_inc = cnt + 1'b1;
    assign same    = cand_vld && (cand_code == track);

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt, rpt_nx, rpt_inc;
    logic             rpt_armed, rpt_armed_nx;

    assign rpt_inc = rpt + 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            track     <= '0;
`ifdef KEYPAD_REPEAT_EN
            rpt       <= '0;
            rpt_armed <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            track     <= track_nx;
`ifdef KEYPAD_REPEAT_EN
            rpt       <= rpt_nx;
            rpt_armed <= rpt_armed_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        track_nx = track;
        emit     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rpt_nx       = rpt;
        rpt_armed_nx = rpt_armed;
`endif
        if (frame_end) begin
            unique case (state)
                ST_IDLE: begin
                    if (cand_vld) begin
                        track_nx = cand_code;
                        cnt_nx   = CNT_W'(1);
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_nx = ST_HELD;
                            emit     = 1'b1;
                        end else begin
                            state_nx = ST_PRESS;
                        end
                    end
                end
                ST_PRESS: begin
                    if (same) begin
                        cnt_nx = cnt_inc;
                        if (cnt_inc == CNT_W'(DEBOUNCE_FRAMES)) begin
                            state_nx = ST_HELD;
                            emit     = 1'b1;
                        end
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (!same) begin
                        cnt_nx   = CNT_W'(1);
                        state_nx = (DEBOUNCE_FRAMES == 1) ? ST_IDLE : ST_RELEASE;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else begin
                        rpt_nx = rpt_inc;
                        if ((!rpt_armed && rpt_inc == RPT_W'(REPEAT_DELAY)) ||
                            ( rpt_armed && rpt_inc == RPT_W'(REPEAT_RATE))) begin
                            emit         = 1'b1;
                            rpt_nx       = '0;
                            rpt_armed_nx = 1'b1;
                        end
                    end
`endif
                end
                ST_RELEASE: begin
                    if (same) begin
                        state_nx = ST_HELD;
                    end else begin
                        cnt_nx = cnt_inc;
                        if (cnt_inc == CNT_W'(DEBOUNCE_FRAMES)) begin
                            state_nx = ST_IDLE;
                        end
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
`ifdef KEYPAD_REPEAT_EN
        // Repeat timing restarts from scratch whenever HELD is left.
        if (state_nx != ST_HELD) begin
            rpt_nx       = '0;
            rpt_armed_nx = 1'b0;
        end
`endif
    end

    assign key_held = (state == ST_HELD) || (state == ST_RELEASE);

    // A new event takes priority over an accept landing on the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid   <= 1'b0;
            key_code    <= '0;
            key_multi   <= 1'b0;
            key_overrun <= 1'b0;
        end else begin
            key_overrun <= 1'b0;
            if (frame_end) begin
                key_multi <= cand_multi;
            end
            if (emit) begin
                if (!key_valid || key_ready) begin
                    key_valid <= 1'b1;
                    key_code  <= track_nx;
                end else begin
                    key_overrun <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench for keypad_matrix_scanner at 4x4, SCAN_DIV=4, DEBOUNCE_FRAMES=3.
// Key matrix is driven per frame; a frame-level reference model predicts every output cycle by cycle.
module tb_keypad_matrix_scanner;

    localparam int DF        = 3;
    localparam int FRAME_CYC = 16;
`ifdef KEYPAD_REPEAT_EN
    localparam int RDELAY = 50;
    localparam int RRATE  = 10;
`endif
    localparam int M_IDLE    = 0;
    localparam int M_PRESS   = 1;
    localparam int M_HELD    = 2;
    localparam int M_RELEASE = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col;
    logic [3:0] row;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] key_code;
    logic       key_held;
    logic       key_multi;
    logic       key_overrun;

    logic [15:0] keys;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int obs_acc = 0;
    int obs_ovr = 0;
    int last_code = -1;
    bit rand_ready = 0;

    int mmode, mcnt, mtrack;
    bit mheld, mmulti, mv;
    int mc;
`ifdef KEYPAD_REPEAT_EN
    int mrpt;
    bit mrep;
`endif

    always #5 clk = ~clk;

    always_comb begin
        col = '0;
        for (int r = 0; r < 4; r++) begin
            if (row[r]) col = col | keys[r*4 +: 4];
        end
    end

    keypad_matrix_scanner #(
        .ROWS            (4),
        .COLS            (4),
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (DF),
        .REPEAT_DELAY    (50),
        .REPEAT_RATE     (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .col         (col),
        .row         (row),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_code    (key_code),
        .key_held    (key_held),
        .key_multi   (key_multi),
        .key_overrun (key_overrun)
    );

    task automatic model_reset();
        mmode = M_IDLE; mcnt = 0; mtrack = 0;
        mheld = 0; mmulti = 0; mv = 0; mc = 0;
`ifdef KEYPAD_REPEAT_EN
        mrpt = 0; mrep = 0;
`endif
    endtask

    // Applies the debounce rules to one complete frame of key closures.
    task automatic model_frame(input logic [15:0] m, output bit emit, output int code);
        int cand;
        int n;
        cand = -1;
        n    = 0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) begin
                cand = i;
                n++;
            end
        end
        emit   = 0;
        mmulti = (n > 1);
        case (mmode)
            M_IDLE: if (cand >= 0) begin
                mtrack = cand; mcnt = 1; mmode = M_PRESS;
            end
            M_PRESS: if (cand == mtrack) begin
                mcnt++;
                if (mcnt == DF) begin
                    mmode = M_HELD; emit = 1;
`ifdef KEYPAD_REPEAT_EN
                    mrpt = 0; mrep = 0;
`endif
                end
            end else begin
                mmode = M_IDLE;
            end
            M_HELD: if (cand != mtrack) begin
                mmode = M_RELEASE; mcnt = 1;
            end else begin
`ifdef KEYPAD_REPEAT_EN
                mrpt++;
                if (mrpt == (mrep ? RRATE : RDELAY)) begin
                    emit = 1; mrpt = 0; mrep = 1;
                end
`endif
            end
            default: if (cand == mtrack) begin
                mmode = M_HELD;
`ifdef KEYPAD_REPEAT_EN
                mrpt = 0; mrep = 0;
`endif
            end else begin
                mcnt++;
                if (mcnt == DF) mmode = M_IDLE;
            end
        endcase
        code  = mtrack;
        mheld = (mmode == M_HELD) || (mmode == M_RELEASE);
    endtask

    task automatic step_cycle();
        bit         acc;
        bit         emit;
        bit         ovr_exp;
        int         ecode;
        logic [3:0] exp_row;
        if (rand_ready) key_ready = 1'($urandom_range(0, 1));
        acc = mv && key_ready;
        if (key_valid && key_ready) begin
            obs_acc++;
            last_code = int'(key_code);
        end
        @(posedge clk);
        #1;
        cyc++;
        emit  = 0;
        ecode = 0;
        if (cyc % FRAME_CYC == 0) model_frame(keys, emit, ecode);
        ovr_exp = 0;
        if (emit) begin
            if (!mv || acc) begin
                mv = 1; mc = ecode;
            end else begin
                ovr_exp = 1;
            end
        end else if (acc) begin
            mv = 0;
        end
        if (key_overrun) obs_ovr++;
        exp_row = 4'b0001 << ((cyc / 4) % 4);
        checks++;
        if (row !== exp_row) begin
            errors++; $display("FAIL row cyc=%0d got=%b exp=%b", cyc, row, exp_row);
        end
        checks++;
        if (key_valid !== mv) begin
            errors++; $display("FAIL key_valid cyc=%0d got=%b exp=%b", cyc, key_valid, mv);
        end
        if (mv) begin
            checks++;
            if (key_code !== 4'(mc)) begin
                errors++; $display("FAIL key_code cyc=%0d got=%0d exp=%0d", cyc, key_code, mc);
            end
        end
        checks++;
        if (key_overrun !== ovr_exp) begin
            errors++; $display("FAIL key_overrun cyc=%0d got=%b exp=%b", cyc, key_overrun, ovr_exp);
        end
        checks++;
        if (key_held !== mheld) begin
            errors++; $display("FAIL key_held cyc=%0d got=%b exp=%b", cyc, key_held, mheld);
        end
        checks++;
        if (key_multi !== mmulti) begin
            errors++; $display("FAIL key_multi cyc=%0d got=%b exp=%b", cyc, key_multi, mmulti);
        end
    endtask

    task automatic run_frames(input logic [15:0] m, input int n);
        keys = m;
        for (int f = 0; f < n; f++) begin
            for (int c = 0; c < FRAME_CYC; c++) step_cycle();
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        keys = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; keys = '0; key_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (row !== 4'b0001 || key_valid !== 1'b0 || key_held !== 1'b0 ||
            key_multi !== 1'b0 || key_overrun !== 1'b0 || key_code !== 4'd0) begin
            errors++;
            $display("FAIL reset_state row=%b v=%b h=%b m=%b o=%b code=%0d exp row=0001 rest 0",
                     row, key_valid, key_held, key_multi, key_overrun, key_code);
        end
        rst = 1'b0;
        cyc = 0;
        model_reset();
        run_frames(16'h0000, 7);
    endtask

    task automatic test_single_press();
        int base;
        key_ready = 1'b1;
        base = obs_acc;
        run_frames(16'h0001 << 9, 5);
        run_frames(16'h0000, 5);
        checks++;
        if (obs_acc - base != 1 || last_code != 9) begin
            errors++; $display("FAIL single_press events=%0d code=%0d exp 1 / 9", obs_acc - base, last_code);
        end
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL single_release key_held=%b exp 0", key_held);
        end
    endtask

    task automatic test_bounce();
        int base;
        key_ready = 1'b1;
        base = obs_acc;
        for (int i = 0; i < 5; i++) run_frames((i % 2 == 0) ? (16'h0001 << 7) : 16'h0000, 1);
        run_frames(16'h0001 << 7, 5);
        run_frames(16'h0000, 4);
        checks++;
        if (obs_acc - base != 1 || last_code != 7) begin
            errors++; $display("FAIL bounce events=%0d code=%0d exp 1 / 7", obs_acc - base, last_code);
        end
    endtask

    task automatic test_multi();
        key_ready = 1'b1;
        run_frames(16'h8001, 4);
        checks++;
        if (last_code != 0 || key_multi !== 1'b1) begin
            errors++; $display("FAIL multi code=%0d multi=%b exp 0 / 1", last_code, key_multi);
        end
        run_frames(16'h0000, 4);
    endtask

    task automatic test_overrun();
        int ovr_base;
        key_ready = 1'b0;
        ovr_base  = obs_ovr;
        run_frames(16'h0001 << 5, 4);
        run_frames(16'h0000, 4);
        run_frames(16'h0001 << 6, 4);
        run_frames(16'h0000, 4);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd5 || obs_ovr - ovr_base != 1) begin
            errors++;
            $display("FAIL overrun valid=%b code=%0d pulses=%0d exp 1 / 5 / 1",
                     key_valid, key_code, obs_ovr - ovr_base);
        end
        key_ready = 1'b1;
        run_frames(16'h0000, 1);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL overrun_drain key_valid=%b exp 0", key_valid);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        key_ready = 1'b1;
        base = obs_acc;
        run_frames(16'h0001 << 3, 4);
        run_frames(16'h0001 << 12, 6);
        run_frames(16'h0000, 4);
        checks++;
        if (obs_acc - base != 2 || last_code != 12) begin
            errors++; $display("FAIL back_to_back events=%0d code=%0d exp 2 / 12", obs_acc - base, last_code);
        end
    endtask

    task automatic test_random();
        logic [15:0] m;
        int          pick;
        rand_ready = 1;
        for (int s = 0; s < 30; s++) begin
            pick = $urandom_range(0, 9);
            if (pick < 5)      m = 16'h0001 << $urandom_range(0, 15);
            else if (pick < 7) m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            else               m = 16'h0000;
            run_frames(m, $urandom_range(1, 6));
        end
        rand_ready = 0;
        key_ready  = 1'b1;
        run_frames(16'h0000, 4);
    endtask

    task automatic test_hold_long();
        int base;
        int exp_ev;
`ifdef KEYPAD_REPEAT_EN
        exp_ev = 3;
`else
        exp_ev = 1;
`endif
        key_ready = 1'b1;
        base = obs_acc;
        run_frames(16'h0001 << 2, 70);
        run_frames(16'h0000, 4);
        checks++;
        if (obs_acc - base != exp_ev || last_code != 2) begin
            errors++; $display("FAIL hold_long events=%0d code=%0d exp %0d / 2", obs_acc - base, last_code, exp_ev);
        end
    endtask

    task automatic test_reset_mid_dwell();
        key_ready = 1'b0;
        run_frames(16'h0001 << 10, 3);
        step_cycle();
        step_cycle();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (row !== 4'b0001 || key_valid !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL async_reset row=%b valid=%b held=%b exp 0001 / 0 / 0", row, key_valid, key_held);
        end
        keys = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        model_reset();
        key_ready = 1'b1;
        run_frames(16'h0000, 2);
    endtask

    initial begin
        keys = '0;
        key_ready = 1'b0;
        model_reset();
        test_reset();
        test_single_press();
        test_bounce();
        test_multi();
        test_overrun();
        test_back_to_back();
        test_random();
        test_hold_long();
        test_reset_mid_dwell();
        do_reset();
        run_frames(16'h0000, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
